uart_tx_fifo_cfg: RTL

Next-generation UART transmitter. Adds an input FIFO, a valid/ready write port and run-time frame configuration: data bits 5..D_W, parity none/even/odd, and 1 or 2 stop bits. It consumes the oversampled tick from baud_gen (B_TICK ticks per bit) and drives baud_en back to it. It sits between the host/bus write logic and the serial pin, replacing the single-byte transmitter.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_fifo.sv | 53 +++++
 rtl/uart_tx_fifo_cfg.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types for the configurable UART transmitter: frame states, parity modes
// and the per-frame configuration latched when a word leaves the FIFO.
package uart_pkg;

  localparam int CFG_DBITS_W = 8;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  typedef struct packed {
    logic [CFG_DBITS_W-1:0] dbits;
    parity_e                parity;
    logic                   stop;
  } uart_cfg_t;

  // The unused encoding 2'b11 is folded onto "no parity".
  function automatic parity_e decode_parity(input logic [1:0] p);
    parity_e r;
    case (p)
      2'b01:   r = PAR_EVEN;
      2'b10:   r = PAR_ODD;
      default: r = PAR_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with combinational read port: rd_data always shows the oldest word.
module uart_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [W-1:0]                 wr_data,
  input  logic                         rd_en,
  output logic [W-1:0]                 rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter fed from a FIFO, with frame format (data bits, parity, stop bits)
// sampled per frame at the moment its word is popped.
module uart_tx_fifo_cfg #(
  parameter int D_W    = 8,
  parameter int B_TICK = 16,
  parameter int FIFO_D = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         baud_clk,
  output logic                         baud_en,
  input  logic [D_W-1:0]               input_data,
  input  logic                         tx_start,
  output logic                         tx_ready,
  input  logic [$clog2(D_W+1)-1:0]     cfg_dbits,
  input  logic [1:0]                   cfg_parity,
  input  logic                         cfg_stop,
  output logic                         tx_data,
  output logic                         tx_done,
  output logic                         tx_busy,
  output logic [$clog2(FIFO_D+1)-1:0]  fifo_count
);

  import uart_pkg::*;

  localparam int DB_W = $clog2(D_W+1);
  localparam int TW   = (B_TICK > 1) ? $clog2(B_TICK) : 1;

  localparam logic [CFG_DBITS_W-1:0] MIN_DBITS = CFG_DBITS_W'(5);
  localparam logic [CFG_DBITS_W-1:0] MAX_DBITS = CFG_DBITS_W'(D_W);

  function automatic logic [CFG_DBITS_W-1:0] clamp_dbits(input logic [DB_W-1:0] d);
    logic [CFG_DBITS_W-1:0] v;
    v = CFG_DBITS_W'(d);
    if (v < MIN_DBITS)      v = MIN_DBITS;
    else if (v > MAX_DBITS) v = MAX_DBITS;
    return v;
  endfunction

  logic [D_W-1:0]         rd_data;
  logic [D_W-1:0]         shreg;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  tx_state_e              state;
  logic [TW-1:0]          tick_cnt;
  logic [CFG_DBITS_W-1:0] bit_cnt;
  logic                   par_acc;
  uart_cfg_t              cfg_q;
  logic                   slot_end;
  logic                   stop_last;
  logic                   data_last;
  logic                   par_next;

  uart_fifo #(
    .W     (D_W),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_start),
    .wr_data (input_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  assign tx_ready  = !full;
  assign push      = tx_start && !full;
  assign slot_end  = baud_clk && (state != IDLE) && (tick_cnt == TW'(B_TICK-1));
  assign stop_last = !cfg_q.stop || (bit_cnt == CFG_DBITS_W'(1));
  assign data_last = (bit_cnt == cfg_q.dbits - CFG_DBITS_W'(1));
  assign par_next  = par_acc ^ shreg[0];

  // A new word is taken either from idle or straight out of the final stop tick,
  // so back-to-back frames have no idle gap.
  assign pop = !empty && ((state == IDLE) || ((state == STOP) && slot_end && stop_last));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      tx_data  <= 1'b1;
      tx_done  <= 1'b0;
      tx_busy  <= 1'b0;
      baud_en  <= 1'b0;
    end else begin
      tx_done <= (state == STOP) && slot_end && stop_last;
      tx_busy <= (state != IDLE) || pop;
      baud_en <= (state != IDLE) || (fifo_count != '0) || push;

      // The tick that lands on a pop is discarded; counting restarts from zero.
      if (pop)
        tick_cnt <= '0;
      else if (baud_clk && (state != IDLE))
        tick_cnt <= slot_end ? '0 : tick_cnt + 1'b1;

      if (pop) begin
        state   <= START;
        tx_data <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: tx_data <= 1'b1;
          START: begin
            if (slot_end) begin
              state   <= DATA;
              tx_data <= shreg[0];
            end
          end
          DATA: begin
            if (slot_end) begin
              if (data_last) begin
                bit_cnt <= '0;
                if (cfg_q.parity != PAR_NONE) begin
                  state   <= PARITY;
                  tx_data <= par_next ^ (cfg_q.parity == PAR_ODD);
                end else begin
                  state   <= STOP;
                  tx_data <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                tx_data <= shreg[1];
              end
            end
          end
          PARITY: begin
            if (slot_end) begin
              state   <= STOP;
              tx_data <= 1'b1;
            end
          end
          STOP: begin
            if (slot_end) begin
              if (stop_last) begin
                state   <= IDLE;
                tx_data <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Frame payload and format: loaded on pop, consumed LSB first while in DATA.
  always_ff @(posedge clk) begin
    if (pop) begin
      shreg        <= rd_data;
      cfg_q.dbits  <= clamp_dbits(cfg_dbits);
      cfg_q.parity <= decode_parity(cfg_parity);
      cfg_q.stop   <= cfg_stop;
      par_acc      <= 1'b0;
    end else if ((state == DATA) && slot_end) begin
      shreg   <= {1'b0, shreg[D_W-1:1]};
      par_acc <= par_next;
    end
  end

endmodule
